// File: rtl/uart_packet_assembler.sv
// Packs the UART receive byte stream into PACKET_BYTES-wide host packets.
// It has an assembly buffer, an output register, an inter-byte timeout and drop accounting.
module uart_packet_assembler #(
    parameter int PACKET_BYTES   = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            rx_valid,
    input  logic [7:0]                      rx_data,
    output logic                            packet_valid,
    input  logic                            packet_ready,
    output logic [8*PACKET_BYTES-1:0]       packet_data,
    output logic [$clog2(PACKET_BYTES):0]   byte_count,
    output logic                            timeout_pulse,
    output logic                            overflow,
    output logic [DROP_CNT_WIDTH-1:0]       drop_count,
    input  logic                            clear_errors
);
    localparam int CW  = $clog2(PACKET_BYTES) + 1;
    localparam int IXW = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
    localparam int IW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(PACKET_BYTES - 1);
    localparam logic [CW-1:0] FULL      = CW'(PACKET_BYTES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                             state, state_nxt;
    logic [PACKET_BYTES-1:0][7:0]       asm_buf, buf_nxt;
    logic [PACKET_BYTES-1:0][7:0]       out_buf, out_nxt;
    logic [CW-1:0]                      bc_nxt;
    logic [IW-1:0]                      idle_cnt, idle_nxt;
    logic                               pv_nxt, tp_nxt, drop;
    logic                               handshake, out_free;

    assign handshake   = packet_valid && packet_ready;
    assign out_free    = !packet_valid || packet_ready;
    assign packet_data = out_buf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= COLLECT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        buf_nxt   = asm_buf;
        out_nxt   = out_buf;
        bc_nxt    = byte_count;
        idle_nxt  = idle_cnt;
        pv_nxt    = packet_valid;
        tp_nxt    = 1'b0;
        drop      = 1'b0;
        case (state)
            COLLECT: begin
                if (handshake) pv_nxt = 1'b0;
                if (rx_valid) begin
                    buf_nxt[byte_count[IXW-1:0]] = rx_data;
                    idle_nxt = '0;
                    if (byte_count == LAST_SLOT) begin
                        // Final byte bypasses into the output register when it is free.
                        if (out_free) begin
                            out_nxt = buf_nxt;
                            pv_nxt  = 1'b1;
                            bc_nxt  = '0;
                        end else begin
                            bc_nxt    = FULL;
                            state_nxt = HOLD;
                        end
                    end else begin
                        bc_nxt = byte_count + 1'b1;
                    end
                end else if (byte_count != '0) begin
                    if (idle_cnt == IDLE_LAST) begin
                        bc_nxt   = '0;
                        idle_nxt = '0;
                        tp_nxt   = 1'b1;
                    end else begin
                        idle_nxt = idle_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                // Receiver cannot stall: anything arriving here is lost, even on the transfer edge.
                drop     = rx_valid;
                idle_nxt = '0;
                if (handshake) begin
                    out_nxt   = asm_buf;
                    bc_nxt    = '0;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_buf       <= '0;
            out_buf       <= '0;
            byte_count    <= '0;
            idle_cnt      <= '0;
            packet_valid  <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            asm_buf       <= buf_nxt;
            out_buf       <= out_nxt;
            byte_count    <= bc_nxt;
            idle_cnt      <= idle_nxt;
            packet_valid  <= pv_nxt;
            timeout_pulse <= tp_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_errors) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end
endmodule
